mmodel_lat: RTL and testbench



---
 rtl/mmodel_lat.sv | 166 ++++++++++++++++
 tb/tb_mmodel_lat.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/mmodel_lat.sv
// Word-array memory model: combinational insn port plus a valid/ready data port with RD_LAT/WR_LAT response latency.
// req_ready drops only while a request is waiting out its latency; responses are one-cycle strobes with no backpressure.
module mmodel_lat #(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned RD_LAT      = 2,
  parameter int unsigned WR_LAT      = 1,
  parameter logic [31:0] HALT_ADDR   = 32'hFFFF_FFF0,
  parameter string       INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] insn_addr,
  output logic [31:0] insn_data,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        halted,
  output logic [31:0] exit_code
);

  localparam int          AW       = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN     = 32'(DEPTH_WORDS * 4);
  localparam logic [31:0] HALT_OFF = HALT_ADDR - BASE_ADDR;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  generate
    if (RD_LAT < 1 || RD_LAT > 15) begin : g_bad_rd_lat
      $error("mmodel_lat: RD_LAT must be 1..15");
    end
    if (WR_LAT < 1 || WR_LAT > 15) begin : g_bad_wr_lat
      $error("mmodel_lat: WR_LAT must be 1..15");
    end
    if (HALT_OFF < SPAN) begin : g_bad_halt
      $error("mmodel_lat: HALT_ADDR lies inside the array");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  logic [31:0] mem [DEPTH_WORDS];

  state_t      st;
  logic [3:0]  cnt;
  logic        l_we;
  logic [31:0] l_addr;
  logic [31:0] l_wdata;
  logic [3:0]  l_be;

  logic        accept;
  logic [3:0]  lat_sel;
  logic        fire_now;
  logic        fire_wait;
  logic        fire;
  logic        c_we;
  logic [31:0] c_addr;
  logic [31:0] c_wdata;
  logic [3:0]  c_be;
  logic [31:0] c_off;
  logic        c_in;
  logic        c_halt;
  logic        c_err;
  logic [AW-1:0] c_idx;
  logic [31:0] rd_word;
  logic        mem_wr;
  logic [31:0] i_off;

  assign accept    = req_valid & req_ready;
  assign lat_sel   = req_we ? 4'(WR_LAT) : 4'(RD_LAT);
  // Single-cycle latency commits straight from the request bus on the accept edge.
  assign fire_now  = accept && (lat_sel == 4'd1);
  assign fire_wait = (st == S_WAIT) && (cnt == 4'd1);
  assign fire      = fire_now | fire_wait;

  always_comb begin
    c_we    = l_we;
    c_addr  = l_addr;
    c_wdata = l_wdata;
    c_be    = l_be;
    if (fire_now) begin
      c_we    = req_we;
      c_addr  = req_addr;
      c_wdata = req_wdata;
      c_be    = req_be;
    end
  end

  assign c_off  = c_addr - BASE_ADDR;
  assign c_in   = c_off < SPAN;
  assign c_halt = c_addr == HALT_ADDR;
  assign c_err  = (|c_addr[1:0]) | (!c_in && !c_halt) | (c_halt && c_we && c_be != 4'hF);
  assign c_idx  = c_off[AW+1:2];
  assign mem_wr = fire && c_we && !c_err && c_in;

  always_comb begin
    rd_word = 32'h0;
    if (!c_err && !c_we) begin
      rd_word = c_halt ? exit_code : mem[c_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && mem_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (c_be[i]) mem[c_idx][8*i +: 8] <= c_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st         <= S_IDLE;
      cnt        <= 4'd0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= 32'h0;
      resp_err   <= 1'b0;
      halted     <= 1'b0;
      exit_code  <= 32'h0;
      l_we       <= 1'b0;
      l_addr     <= 32'h0;
      l_wdata    <= 32'h0;
      l_be       <= 4'h0;
    end else begin
      resp_valid <= 1'b0;
      resp_rdata <= 32'h0;
      resp_err   <= 1'b0;
      if (accept) begin
        l_we    <= req_we;
        l_addr  <= req_addr;
        l_wdata <= req_wdata;
        l_be    <= req_be;
      end
      if (fire) begin
        st         <= S_RESP;
        req_ready  <= 1'b1;
        resp_valid <= 1'b1;
        resp_err   <= c_err;
        resp_rdata <= rd_word;
        if (c_we && c_halt && !c_err) begin
          halted    <= 1'b1;
          exit_code <= c_wdata;
        end
      end else if (accept) begin
        st        <= S_WAIT;
        req_ready <= 1'b0;
        cnt       <= lat_sel - 4'd1;
      end else if (st == S_WAIT) begin
        cnt <= cnt - 4'd1;
      end else begin
        st        <= S_IDLE;
        req_ready <= 1'b1;
      end
    end
  end

  assign i_off     = insn_addr - BASE_ADDR;
  assign insn_data = ((|insn_addr[1:0]) || i_off >= SPAN) ? NOP : mem[i_off[AW+1:2]];

endmodule

// File: tb/tb_mmodel_lat.sv
// Directed bench for mmodel_lat: one instance at RD_LAT=3/WR_LAT=4, one at single-cycle latency for chaining.
module tb_mmodel_lat;

  localparam int unsigned DEPTH = 256;
  localparam logic [31:0] HALT  = 32'hFFFF_FFF0;

  logic clk;
  int   total  = 0;
  int   passed = 0;

  logic        a_rst, a_req_valid, a_req_ready, a_req_we, a_resp_valid, a_resp_err, a_halted;
  logic [31:0] a_insn_addr, a_insn_data, a_req_addr, a_req_wdata, a_resp_rdata, a_exit_code;
  logic [3:0]  a_req_be;

  logic        b_rst, b_req_valid, b_req_ready, b_req_we, b_resp_valid, b_resp_err, b_halted;
  logic [31:0] b_insn_addr, b_insn_data, b_req_addr, b_req_wdata, b_resp_rdata, b_exit_code;
  logic [3:0]  b_req_be;

  mmodel_lat #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(32'h0), .RD_LAT(3), .WR_LAT(4),
               .HALT_ADDR(HALT), .INIT_FILE("")) u_a (
    .clk(clk), .rst(a_rst), .insn_addr(a_insn_addr), .insn_data(a_insn_data),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_we(a_req_we),
    .req_addr(a_req_addr), .req_wdata(a_req_wdata), .req_be(a_req_be),
    .resp_valid(a_resp_valid), .resp_rdata(a_resp_rdata), .resp_err(a_resp_err),
    .halted(a_halted), .exit_code(a_exit_code)
  );

  mmodel_lat #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(32'h0), .RD_LAT(1), .WR_LAT(1),
               .HALT_ADDR(HALT), .INIT_FILE("")) u_b (
    .clk(clk), .rst(b_rst), .insn_addr(b_insn_addr), .insn_data(b_insn_data),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_be(b_req_be),
    .resp_valid(b_resp_valid), .resp_rdata(b_resp_rdata), .resp_err(b_resp_err),
    .halted(b_halted), .exit_code(b_exit_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // One request on u_a; snapshots outputs during the response cycle, then steps past it.
  task automatic a_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, output logic [31:0] rdata, output logic err,
                       output int lat, output logic [31:0] insn, output logic hlt);
    a_req_valid = 1'b1;
    a_req_we    = we;
    a_req_addr  = addr;
    a_req_wdata = wdata;
    a_req_be    = be;
    step();
    a_req_valid = 1'b0;
    lat = 1;
    while (!a_resp_valid && lat < 20) begin
      step();
      lat++;
    end
    rdata = a_resp_rdata;
    err   = a_resp_err;
    insn  = a_insn_data;
    hlt   = a_halted;
    step();
  endtask

  task automatic b_write(input logic [31:0] addr, input logic [31:0] wdata);
    b_req_valid = 1'b1;
    b_req_we    = 1'b1;
    b_req_addr  = addr;
    b_req_wdata = wdata;
    b_req_be    = 4'hF;
    step();
    b_req_valid = 1'b0;
    step();
  endtask

  logic [31:0] rd, insn;
  logic        err, hlt;
  int          lat, pulses;
  logic [31:0] bdat [4] = '{32'h1111_0000, 32'h2222_0001, 32'h3333_0002, 32'h4444_0003};

  initial begin
    a_rst = 1'b1; a_req_valid = 1'b0; a_req_we = 1'b0; a_req_addr = 32'h0;
    a_req_wdata = 32'h0; a_req_be = 4'h0; a_insn_addr = 32'h100;
    b_rst = 1'b1; b_req_valid = 1'b0; b_req_we = 1'b0; b_req_addr = 32'h0;
    b_req_wdata = 32'h0; b_req_be = 4'h0; b_insn_addr = 32'h0;
    repeat (3) step();
    a_rst = 1'b0;
    b_rst = 1'b0;

    chk("rst_req_ready", 32'(a_req_ready), 32'd1);
    chk("rst_resp_valid", 32'(a_resp_valid), 32'd0);
    chk("rst_resp_rdata", a_resp_rdata, 32'h0);
    chk("rst_resp_err", 32'(a_resp_err), 32'd0);
    chk("rst_halted", 32'(a_halted), 32'd0);
    chk("rst_exit_code", a_exit_code, 32'h0);

    // Full-word write, then read back with latency measured from the accept cycle.
    a_txn(1'b1, 32'h100, 32'hDEAD_BEEF, 4'hF, rd, err, lat, insn, hlt);
    chk("wr_lat", 32'(lat), 32'd4);
    chk("wr_err", 32'(err), 32'd0);
    chk("wr_rdata_zero", rd, 32'h0);
    chk("insn_in_resp", insn, 32'hDEAD_BEEF);
    a_txn(1'b0, 32'h100, 32'h0, 4'h0, rd, err, lat, insn, hlt);
    chk("rd_lat", 32'(lat), 32'd3);
    chk("rd_data", rd, 32'hDEAD_BEEF);
    chk("rd_err", 32'(err), 32'd0);
    chk("insn_0x100", a_insn_data, 32'hDEAD_BEEF);

    a_txn(1'b1, 32'h100, 32'h1122_3344, 4'b0101, rd, err, lat, insn, hlt);
    chk("be_wr_err", 32'(err), 32'd0);
    a_txn(1'b0, 32'h100, 32'h0, 4'h0, rd, err, lat, insn, hlt);
    chk("be_rd_data", rd, 32'hDE22_BE44);
    a_txn(1'b1, 32'h100, 32'hFFFF_FFFF, 4'h0, rd, err, lat, insn, hlt);
    chk("be0_err", 32'(err), 32'd0);
    a_txn(1'b0, 32'h100, 32'h0, 4'h0, rd, err, lat, insn, hlt);
    chk("be0_unchanged", rd, 32'hDE22_BE44);

    a_txn(1'b0, 32'h102, 32'h0, 4'h0, rd, err, lat, insn, hlt);
    chk("mis_rd_err", 32'(err), 32'd1);
    chk("mis_rd_data", rd, 32'h0);
    chk("mis_rd_lat", 32'(lat), 32'd3);
    a_txn(1'b1, 32'h0, 32'h1234_5678, 4'hF, rd, err, lat, insn, hlt);
    a_txn(1'b1, 32'(DEPTH * 4), 32'hCAFE_F00D, 4'hF, rd, err, lat, insn, hlt);
    chk("oor_wr_err", 32'(err), 32'd1);
    chk("oor_wr_lat", 32'(lat), 32'd4);
    a_txn(1'b0, 32'h0, 32'h0, 4'h0, rd, err, lat, insn, hlt);
    chk("oor_no_alias", rd, 32'h1234_5678);
    a_insn_addr = 32'(DEPTH * 4);
    #1;
    chk("insn_oor_nop", a_insn_data, 32'h0000_0013);
    a_insn_addr = 32'h102;
    #1;
    chk("insn_mis_nop", a_insn_data, 32'h0000_0013);

    a_txn(1'b1, HALT, 32'h2A, 4'hF, rd, err, lat, insn, hlt);
    chk("halt_in_resp", 32'(hlt), 32'd1);
    chk("halt_err", 32'(err), 32'd0);
    chk("halt_exit", a_exit_code, 32'h2A);
    a_txn(1'b1, HALT, 32'h99, 4'h3, rd, err, lat, insn, hlt);
    chk("halt_part_err", 32'(err), 32'd1);
    chk("halt_part_exit", a_exit_code, 32'h2A);
    a_txn(1'b0, HALT, 32'h0, 4'h0, rd, err, lat, insn, hlt);
    chk("halt_rd", rd, 32'h2A);
    a_txn(1'b1, HALT, 32'h7, 4'hF, rd, err, lat, insn, hlt);
    a_txn(1'b0, 32'h100, 32'h0, 4'h0, rd, err, lat, insn, hlt);
    chk("halt_sticky", 32'(a_halted), 32'd1);
    chk("halt_exit_upd", a_exit_code, 32'h7);

    // Reset two cycles into a 4-cycle write must drop it entirely.
    a_txn(1'b1, 32'h200, 32'hA5A5_A5A5, 4'hF, rd, err, lat, insn, hlt);
    a_req_valid = 1'b1; a_req_we = 1'b1; a_req_addr = 32'h200;
    a_req_wdata = 32'h55; a_req_be = 4'hF;
    step();
    a_req_valid = 1'b0;
    step();
    a_rst = 1'b1;
    step();
    a_rst = 1'b0;
    chk("mid_rst_ready", 32'(a_req_ready), 32'd1);
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      if (a_resp_valid) pulses++;
      step();
    end
    chk("mid_rst_no_resp", 32'(pulses), 32'd0);
    chk("mid_rst_halted", 32'(a_halted), 32'd0);
    chk("mid_rst_exit", a_exit_code, 32'h0);
    a_txn(1'b0, 32'h200, 32'h0, 4'h0, rd, err, lat, insn, hlt);
    chk("mid_rst_mem", rd, 32'hA5A5_A5A5);

    // Single-cycle instance: reads chained with req_valid held high.
    for (int i = 0; i < 4; i++) b_write(32'h10 + 32'(4 * i), bdat[i]);
    b_req_valid = 1'b1;
    b_req_we    = 1'b0;
    for (int i = 0; i < 4; i++) begin
      b_req_addr = 32'h10 + 32'(4 * i);
      step();
      chk("b2b_valid", 32'(b_resp_valid), 32'd1);
      chk("b2b_data", b_resp_rdata, bdat[i]);
      chk("b2b_ready", 32'(b_req_ready), 32'd1);
    end
    b_req_valid = 1'b0;
    step();
    chk("b2b_done", 32'(b_resp_valid), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
